// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: header lane offsets, broadcast MAC and parser states.
// Broadcast acceptance in eth_rx_hdr_strip is enabled by defining ETH_RX_BCAST_EN.
package eth_pkg;

    localparam int DST_MAC_LANE  = 0;
    localparam int ETYPE_LANE    = 4;
    localparam int ETH_HDR_BYTES = 14;
    // First payload lane within the second header beat.
    localparam int PAY_LANE      = ETH_HDR_BYTES - 8;

    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_DROP
    } eth_state_e;

    function automatic logic [47:0] get_dst_mac(input logic [63:0] d);
        logic [47:0] mac;
        for (int i = 0; i < 6; i++) begin
            mac[47-8*i -: 8] = d[8*(DST_MAC_LANE+i) +: 8];
        end
        return mac;
    endfunction

    function automatic logic [15:0] get_etype(input logic [63:0] d);
        return {d[8*ETYPE_LANE +: 8], d[8*(ETYPE_LANE+1) +: 8]};
    endfunction

endpackage

// File: rtl/eth_rx_hdr_strip.sv
// Drops frames not addressed to us, strips the 14-byte header and realigns payload to lane 0.
// Optional ETH_RX_BCAST_EN: also accept the broadcast destination address.
module eth_rx_hdr_strip
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic [15:0]      m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_drop
);

    eth_state_e state_q, state_d;

    logic [15:0]      res_q, res_d;
    logic [1:0]       res_keep_q, res_keep_d;
    logic [15:0]      etype_q, etype_d;
    logic [63:0]      m_data_q, m_data_d;
    logic [7:0]       m_keep_q, m_keep_d;
    logic             m_last_q, m_last_d;
    logic [15:0]      m_user_q, m_user_d;
    logic             m_valid_q, m_valid_d;
    logic [CNT_W-1:0] ok_q, ok_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic        in_fire;
    logic        out_free;
    logic        hdr_hit;
    logic        pay_more;
    logic [47:0] dst_mac;

    logic ld_etype;
    logic ld_res;
    logic ld_pay;
    logic ld_flush;
    logic ok_inc;
    logic drop_inc;

    assign dst_mac  = get_dst_mac(s_axis_tdata);
    assign pay_more = s_axis_tkeep[PAY_LANE];
    assign out_free = !m_valid_q || m_axis_tready;
    assign in_fire  = s_axis_tvalid && s_axis_tready;

`ifdef ETH_RX_BCAST_EN
    assign hdr_hit = (dst_mac == MAC_ADDR_FPGA) || (dst_mac == BCAST_MAC);
`else
    assign hdr_hit = (dst_mac == MAC_ADDR_FPGA);
`endif

    // Ready is held low during reset so nothing is consumed before the parser is live.
    assign s_axis_tready = aresetn && (
        (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DROP) ||
        ((state_q == ST_PAYLOAD) && out_free));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HDR0: begin
                if (in_fire && !s_axis_tlast) begin
                    state_d = hdr_hit ? ST_HDR1 : ST_DROP;
                end
            end
            ST_HDR1: begin
                if (in_fire) begin
                    if (!s_axis_tlast) begin
                        state_d = ST_PAYLOAD;
                    end else if (pay_more) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_HDR0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_fire && s_axis_tlast) begin
                    state_d = pay_more ? ST_FLUSH : ST_HDR0;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    state_d = ST_HDR0;
                end
            end
            ST_DROP: begin
                if (in_fire && s_axis_tlast) begin
                    state_d = ST_HDR0;
                end
            end
            default: state_d = ST_HDR0;
        endcase
    end

    always_comb begin
        ld_etype = 1'b0;
        ld_res   = 1'b0;
        ld_pay   = 1'b0;
        ld_flush = 1'b0;
        ok_inc   = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            ST_HDR0: begin
                drop_inc = in_fire && s_axis_tlast;
            end
            ST_HDR1: begin
                ld_etype = in_fire;
                ld_res   = in_fire;
                drop_inc = in_fire && s_axis_tlast && !pay_more;
            end
            ST_PAYLOAD: begin
                ld_pay = in_fire;
                ld_res = in_fire;
                ok_inc = in_fire && s_axis_tlast && !pay_more;
            end
            ST_FLUSH: begin
                ld_flush = out_free;
                ok_inc   = out_free;
            end
            ST_DROP: begin
                drop_inc = in_fire && s_axis_tlast;
            end
            default: ;
        endcase
    end

    always_comb begin
        res_d      = res_q;
        res_keep_d = res_keep_q;
        etype_d    = etype_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_user_d   = m_user_q;
        m_valid_d  = m_valid_q;
        ok_d       = ok_q;
        drop_d     = drop_q;

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        if (ld_etype) begin
            etype_d = get_etype(s_axis_tdata);
        end
        if (ld_res) begin
            res_d      = s_axis_tdata[8*PAY_LANE +: 16];
            res_keep_d = s_axis_tkeep[PAY_LANE +: 2];
        end
        // Residue takes lanes 0-1; the new beat shifts up by two lanes.
        if (ld_pay) begin
            m_valid_d = 1'b1;
            m_data_d  = {s_axis_tdata[8*PAY_LANE-1:0], res_q};
            m_keep_d  = {s_axis_tkeep[PAY_LANE-1:0], 2'b11};
            m_last_d  = s_axis_tlast && !pay_more;
            m_user_d  = etype_q;
        end
        if (ld_flush) begin
            m_valid_d = 1'b1;
            m_data_d  = {48'h0, res_q};
            m_keep_d  = {6'b0, res_keep_q};
            m_last_d  = 1'b1;
            m_user_d  = etype_q;
        end
        if (ok_inc && (ok_q != '1)) begin
            ok_d = ok_q + 1'b1;
        end
        if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            res_q      <= '0;
            res_keep_q <= '0;
            etype_q    <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_user_q   <= '0;
            m_valid_q  <= 1'b0;
            ok_q       <= '0;
            drop_q     <= '0;
        end else begin
            res_q      <= res_d;
            res_keep_q <= res_keep_d;
            etype_q    <= etype_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_user_q   <= m_user_d;
            m_valid_q  <= m_valid_d;
            ok_q       <= ok_d;
            drop_q     <= drop_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tvalid = m_valid_q;
    assign frames_ok     = ok_q;
    assign frames_drop   = drop_q;

endmodule

// File: tb/tb_eth_rx_hdr_strip.sv
// Directed bench for eth_rx_hdr_strip: filtering, realignment, runts, backpressure, reset abort.
// Broadcast expectations follow ETH_RX_BCAST_EN.
module tb_eth_rx_hdr_strip;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [15:0] m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;

    eth_rx_hdr_strip dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frames_ok     (frames_ok),
        .frames_drop   (frames_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [15:0] u;
    } ob_t;

    ob_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  stalls = 0;
    bit  tog = 1'b0;

    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) m_axis_tready = ~m_axis_tready;
            else     m_axis_tready = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic chk_beat(input string tag, input int idx, input logic [63:0] d,
                            input logic [7:0] k, input logic l, input logic [15:0] u);
        if (q.size() > idx) begin
            chk({tag, "_keep"}, {56'h0, q[idx].k}, {56'h0, k});
            chk({tag, "_data"}, q[idx].d & kmask(k), d & kmask(k));
            chk({tag, "_last"}, {63'h0, q[idx].l}, {63'h0, l});
            chk({tag, "_user"}, {48'h0, q[idx].u}, {48'h0, u});
        end else begin
            tests++;
            fails++;
            $display("FAIL %s missing beat observed=%0d beats expected>%0d", tag, q.size(), idx);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        bit done;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) begin
                done = 1'b1;
            end else begin
                stalls++;
                n++;
                if (n > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout observed=stalled expected=accept");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] B0_OK = 64'h2211_02ca_553e_16fa;
    localparam logic [63:0] B0_MISS = 64'h2211_47c0_887a_c40c;
    localparam logic [63:0] B0_BC = 64'h2211_ffff_ffff_ffff;
    localparam logic [63:0] B1_IP = 64'ha1a0_0008_6655_4433;
    localparam logic [63:0] B1_V6 = 64'ha1a0_dd86_6655_4433;

    initial begin
        logic [63:0] d;
        #2;
        chk("rst_tready", {63'h0, s_axis_tready}, 64'h0);
        chk("rst_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
        chk("rst_tdata", m_axis_tdata, 64'h0);
        chk("rst_tkeep", {56'h0, m_axis_tkeep}, 64'h0);
        chk("rst_tlast", {63'h0, m_axis_tlast}, 64'h0);
        chk("rst_tuser", {48'h0, m_axis_tuser}, 64'h0);
        chk("rst_ok", {48'h0, frames_ok}, 64'h0);
        chk("rst_drop", {48'h0, frames_drop}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat frame, full final beat: two outputs
        q.delete();
        send(B0_OK, 8'hff, 1'b0);
        send(B1_IP, 8'hff, 1'b0);
        send(64'hb7b6_b5b4_b3b2_b1b0, 8'hff, 1'b1);
        drain();
        chk("t1_count", q.size(), 2);
        chk_beat("t1_b0", 0, 64'hb5b4_b3b2_b1b0_a1a0, 8'hff, 1'b0, 16'h0800);
        chk_beat("t1_b1", 1, 64'h0000_0000_0000_b7b6, 8'h03, 1'b1, 16'h0800);
        chk("t1_ok", {48'h0, frames_ok}, 64'd1);

        // same frame, final keep 0f: one output
        q.delete();
        send(B0_OK, 8'hff, 1'b0);
        send(B1_IP, 8'hff, 1'b0);
        send(64'h0000_0000_b3b2_b1b0, 8'h0f, 1'b1);
        drain();
        chk("t2_count", q.size(), 1);
        chk_beat("t2_b0", 0, 64'h0000_b3b2_b1b0_a1a0, 8'h3f, 1'b1, 16'h0800);
        chk("t2_ok", {48'h0, frames_ok}, 64'd2);

        // MAC miss, 4 beats
        q.delete();
        stalls = 0;
        send(B0_MISS, 8'hff, 1'b0);
        send(B1_IP, 8'hff, 1'b0);
        send(64'h1111_1111_1111_1111, 8'hff, 1'b0);
        send(64'h2222_2222_2222_2222, 8'hff, 1'b1);
        chk("t3_stalls", stalls, 0);
        drain();
        chk("t3_count", q.size(), 0);
        chk("t3_drop", {48'h0, frames_drop}, 64'd1);
        chk("t3_ok", {48'h0, frames_ok}, 64'd2);

        // 2-beat frames: one short payload, one runt
        q.delete();
        send(B0_OK, 8'hff, 1'b0);
        send(B1_IP, 8'hff, 1'b1);
        drain();
        chk("t4_count", q.size(), 1);
        chk_beat("t4_b0", 0, 64'h0000_0000_0000_a1a0, 8'h03, 1'b1, 16'h0800);
        chk("t4_ok", {48'h0, frames_ok}, 64'd3);
        q.delete();
        send(B0_OK, 8'hff, 1'b0);
        send(B1_IP, 8'h3f, 1'b1);
        drain();
        chk("t4_runt_count", q.size(), 0);
        chk("t4_runt_drop", {48'h0, frames_drop}, 64'd2);

        // broadcast destination
        q.delete();
        send(B0_BC, 8'hff, 1'b0);
        send(B1_V6, 8'hff, 1'b0);
        send(64'h0000_0000_b3b2_b1b0, 8'h0f, 1'b1);
        drain();
`ifdef ETH_RX_BCAST_EN
        chk("t5_count", q.size(), 1);
        chk_beat("t5_b0", 0, 64'h0000_b3b2_b1b0_a1a0, 8'h3f, 1'b1, 16'h86dd);
        chk("t5_ok", {48'h0, frames_ok}, 64'd4);
        chk("t5_drop", {48'h0, frames_drop}, 64'd2);
`else
        chk("t5_count", q.size(), 0);
        chk("t5_ok", {48'h0, frames_ok}, 64'd3);
        chk("t5_drop", {48'h0, frames_drop}, 64'd3);
`endif

        // 10-beat frame, ready toggling; payload byte n has value n
        q.delete();
        tog = 1'b1;
        send(B0_OK, 8'hff, 1'b0);
        send(64'h0100_b588_6655_4433, 8'hff, 1'b0);
        for (int b = 2; b < 10; b++) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(2 + 8*(b-2) + i);
            send(d, 8'hff, (b == 9));
        end
        repeat (20) @(posedge clk);
        #1;
        tog = 1'b0;
        drain();
        chk("t6_count", q.size(), 9);
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(8*j + i);
            chk_beat($sformatf("t6_b%0d", j), j, d, 8'hff, 1'b0, 16'h88b5);
        end
        chk_beat("t6_b8", 8, 64'h0000_0000_0000_4140, 8'h03, 1'b1, 16'h88b5);

        // reset mid-frame with an output beat pending
        q.delete();
        m_axis_tready = 1'b0;
        tog = 1'b0;
        send(B0_OK, 8'hff, 1'b0);
        send(B1_IP, 8'hff, 1'b0);
        send(64'h1111_1111_1111_1111, 8'hff, 1'b0);
        aresetn = 1'b0;
        #2;
        chk("t7_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
        chk("t7_tdata", m_axis_tdata, 64'h0);
        chk("t7_tkeep", {56'h0, m_axis_tkeep}, 64'h0);
        chk("t7_tlast", {63'h0, m_axis_tlast}, 64'h0);
        chk("t7_tuser", {48'h0, m_axis_tuser}, 64'h0);
        chk("t7_tready", {63'h0, s_axis_tready}, 64'h0);
        chk("t7_ok", {48'h0, frames_ok}, 64'h0);
        chk("t7_drop", {48'h0, frames_drop}, 64'h0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        q.delete();
        send(B0_OK, 8'hff, 1'b0);
        send(B1_IP, 8'hff, 1'b0);
        send(64'hb7b6_b5b4_b3b2_b1b0, 8'hff, 1'b1);
        drain();
        chk("t8_count", q.size(), 2);
        chk_beat("t8_b0", 0, 64'hb5b4_b3b2_b1b0_a1a0, 8'hff, 1'b0, 16'h0800);
        chk_beat("t8_b1", 1, 64'h0000_0000_0000_b7b6, 8'h03, 1'b1, 16'h0800);
        chk("t8_ok", {48'h0, frames_ok}, 64'd1);
        chk("t8_drop", {48'h0, frames_drop}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_rx_hdr_strip.md
# eth_rx_hdr_strip

Receive-side Ethernet stage that sits directly downstream of the network port. Consumes 64-bit AXI-stream frames and drops any whose destination MAC is not the FPGA's. Removes the 14-byte Ethernet header and re-aligns the payload to byte lane 0. Forwards the payload, with the EtherType as sideband, to the packet router.

## Interface
- `MAC_ADDR_FPGA`, 48'hfa163e55ca02, local MAC; frames whose destination matches are accepted.
- `CNT_W`, 16, width of the saturating statistics counters.

- `clk`  in  1  sole clock.
- `aresetn`  in  1  reset, asynchronous assert, active-low.
- `s_axis_tdata`  in  64  frame data; lane i = bits [8i+7:8i]; lane 0 is first on the wire.
- `s_axis_tkeep`  in  8  byte enables; contiguous from lane 0.
- `s_axis_tlast`  in  1  last beat of frame.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  64  payload data.
- `m_axis_tkeep`  out  8  payload byte enables.
- `m_axis_tlast`  out  1  last payload beat.
- `m_axis_tuser`  out  16  EtherType; constant for the whole frame.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `frames_ok`  out  CNT_W  count of accepted frames.
- `frames_drop`  out  CNT_W  count of dropped frames (MAC miss or runt).

## Operation
- Header layout:
  - beat0 lanes 0–5: destination MAC, MSB in lane 0.
  - beat0 lanes 6–7 and beat1 lanes 0–3: source MAC (ignored).
  - beat1 lanes 4–5: EtherType, MSB in lane 4.
  - beat1 lanes 6–7: payload bytes 0–1.
- States: HDR0, HDR1, PAYLOAD, FLUSH, DROP.
- HDR0, on accepting a beat:
  - tlast=1: runt; increment `frames_drop`; stay in HDR0.
  - destination MAC miss: go to DROP.
  - otherwise: go to HDR1.
- HDR1, on accepting a beat:
  - Latch the EtherType into `m_axis_tuser`.
  - Store lanes 6–7 as a 2-byte residue, with residue keep = tkeep[7:6].
  - tlast=0: go to PAYLOAD.
  - tlast=1 and tkeep[6]=1: go to FLUSH.
  - tlast=1 and tkeep[6]=0: runt; increment `frames_drop`; go to HDR0.
- PAYLOAD, on accepting a beat:
  - Emit data = {in lanes 0–5, residue} and keep = {tkeep[5:0], 2'b11}.
  - Store lanes 6–7 as the new residue.
  - On tlast with tkeep[6]=1: emit with tlast=0, then go to FLUSH.
  - On tlast with tkeep[6]=0: emit with tlast=1, increment `frames_ok`, go to HDR0.
- FLUSH:
  - Emit the residue in lanes 0–1, keep = {6'b0, residue keep}, tlast=1.
  - When that beat is accepted, increment `frames_ok` and go to HDR0.
- DROP: consume beats with ready=1; on tlast, increment `frames_drop` and go to HDR0.
- Counters saturate at all-ones.

## Timing
- Reset values: state HDR0, `m_axis_tvalid` 0, `m_axis_tdata`/`tkeep`/`tlast`/`tuser` 0, both counters 0, `s_axis_tready` 0 while `aresetn` is low.
- Output is a single register stage.
- `s_axis_tready` is 1 in HDR0, HDR1 and DROP.
- In PAYLOAD, `s_axis_tready` = !m_axis_tvalid || m_axis_tready.
- In FLUSH, `s_axis_tready` is 0.
- Latency: the output beat appears the cycle after the input beat that completes it. A full-rate frame streams at one beat per cycle with no bubbles.
- Header beats cost 2 input cycles with no output.
- Output fields hold stable while `m_axis_tvalid` && !`m_axis_tready`.
- `aresetn` asserted mid-frame aborts it immediately with no counter update. After release, the block restarts in HDR0; input beats before the next frame start are parsed as a header.

## Configuration
- `ETH_RX_BCAST_EN` defined: a destination of 48'hffffffffffff is also accepted and treated like a matching frame.
- `ETH_RX_BCAST_EN` undefined: broadcast frames take the DROP path and are counted in `frames_drop`.

## Structure
- Shared package `eth_pkg` holds:
  - the byte-lane offsets (`DST_MAC_LANE`=0, `ETYPE_LANE`=4);
  - the header length constant `ETH_HDR_BYTES`=14;
  - the broadcast MAC constant;
  - the state enum.
- No sub-module; the re-alignment datapath and the FSM live in one module.

## Test plan
- 3-beat frame, dst = MAC_ADDR_FPGA, EtherType 16'h0800, beat2 keep 8'hff, last → two out beats:
  - first: keep ff, tlast 0;
  - second: keep 03, tlast 1, `tuser` 0800;
  - `frames_ok`=1.
- Same frame with beat2 keep 8'h0f → one out beat, keep 8'h3f, tlast 1.
- dst 48'h0cc47a88c047, 4 beats → no output, `frames_drop`=1, `s_axis_tready` high throughout.
- 2-beat frame, beat1 keep 8'hff, last → one out beat, keep 8'h03, tlast 1; beat1 keep 8'h3f → runt, `frames_drop`+1.
- Broadcast dst: forwarded with `ETH_RX_BCAST_EN` defined, dropped without it.
- `m_axis_tready` toggled 50% over a 10-beat frame → payload bytes in order, no loss or duplication; `aresetn` pulsed mid-frame → outputs return to reset values and the next frame is parsed correctly.
